// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//   Moore serial sequence detector with a run-time programmable pattern
//   (1..MAX_LEN bits), overlapping / non-overlapping mode, an input qualifier
//   and a saturating match counter. The defaults detect "1001" without overlap.
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   reset_i        synchronous active-high reset (restores DEF_* config)
//   din_i          serial data bit
//   din_valid_i    din_i is sampled only when high
//   cfg_load_i     one-cycle pulse: capture cfg_pattern_i/cfg_len_i/cfg_overlap_i
//   cfg_pattern_i  new pattern; bit [len-1] is the first bit, bit [0] the last
//   cfg_len_i      new pattern length
//   cfg_overlap_i  new mode: 1 = overlapping, 0 = non-overlapping
//   dout_o         registered match flag, high for one cycle per match
//   match_count_o  matches since reset / cfg_load, saturating
//   cfg_err_o      active config invalid (len 0 or > MAX_LEN), detection off
// -----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'h09),
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               din_i,
    input  logic               din_valid_i,
    input  logic               cfg_load_i,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               cfg_overlap_i,
    output logic               dout_o,
    output logic [CNT_W-1:0]   match_count_o,
    output logic               cfg_err_o
);

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // Active configuration
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic               cfg_err_q;

    // Detection state
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               dout_q, dout_d;

    // Combinational helpers
    logic [MAX_LEN-1:0] hist_n_s;
    logic [MAX_LEN-1:0] mask_s;
    logic [LEN_W:0]     fill_inc_s;
    logic               match_s;
    logic               cfg_bad_s;

    // Match detection and next-state computation for history, fill, count, flag
    always_comb begin
        hist_n_s   = {hist_q[MAX_LEN-2:0], din_i};
        // Low len_q bits set; a shift of MAX_LEN or more yields an all-ones mask.
        mask_s     = ~({MAX_LEN{1'b1}} << len_q);
        fill_inc_s = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
        match_s    = din_valid_i && !cfg_err_q
                     && (fill_inc_s >= {1'b0, len_q})
                     && (((hist_n_s ^ pattern_q) & mask_s) == {MAX_LEN{1'b0}});
        cfg_bad_s  = (cfg_len_i == {LEN_W{1'b0}}) || (cfg_len_i > MAX_LEN_V);

        hist_d  = hist_q;
        fill_d  = fill_q;
        count_d = count_q;
        dout_d  = match_s;

        if (match_s && !overlap_q) begin
            // Non-overlapping: the next match must be built from fresh bits.
            hist_d = {MAX_LEN{1'b0}};
            fill_d = {LEN_W{1'b0}};
        end else if (din_valid_i) begin
            hist_d = hist_n_s;
            if (fill_q >= MAX_LEN_V) begin
                fill_d = fill_q;
            end else begin
                fill_d = fill_q + {{(LEN_W-1){1'b0}}, 1'b1};
            end
        end else begin
            // Gap: partial match is preserved.
            hist_d = hist_q;
            fill_d = fill_q;
        end

        if (match_s && (count_q != CNT_MAX)) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // State registers: reset beats cfg_load, cfg_load ignores din on that cycle
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            cfg_err_q <= 1'b0;
            hist_q    <= {MAX_LEN{1'b0}};
            fill_q    <= {LEN_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            dout_q    <= 1'b0;
        end else if (cfg_load_i) begin
            pattern_q <= cfg_pattern_i;
            len_q     <= cfg_len_i;
            overlap_q <= cfg_overlap_i;
            cfg_err_q <= cfg_bad_s;
            hist_q    <= {MAX_LEN{1'b0}};
            fill_q    <= {LEN_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            dout_q    <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
            dout_q    <= dout_d;
        end
    end

    assign dout_o        = dout_q;
    assign match_count_o = count_q;
    assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: stimulus pushes the reference model's expected outputs,
// a monitor pops one entry per clock and compares both DUT instances
// (default CNT_W=8 and a CNT_W=2 copy sharing the same inputs).
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = 8'h00;
    logic [3:0] cfg_len = 4'd0;
    logic       cfg_overlap = 1'b0;

    logic       dout_a, err_a, dout_b, err_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    seq_detector_param dut_a (
        .clk_i(clk), .reset_i(reset), .din_i(din), .din_valid_i(din_valid),
        .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern), .cfg_len_i(cfg_len),
        .cfg_overlap_i(cfg_overlap), .dout_o(dout_a), .match_count_o(cnt_a),
        .cfg_err_o(err_a)
    );

    seq_detector_param #(.CNT_W(2)) dut_b (
        .clk_i(clk), .reset_i(reset), .din_i(din), .din_valid_i(din_valid),
        .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern), .cfg_len_i(cfg_len),
        .cfg_overlap_i(cfg_overlap), .dout_o(dout_b), .match_count_o(cnt_b),
        .cfg_err_o(err_b)
    );

    typedef struct packed {
        logic       dout;
        logic       err;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   pulses = 0;     // dout_a pulses seen by the monitor

    // Reference model: list of valid bits since last clear, plus config
    bit         bits_q[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         m_err;
    int         m_cnt;
    bit         m_dout;

    task automatic check(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    endtask

    function automatic bit tail_matches();
        if (bits_q.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++)
            if (bits_q[bits_q.size()-1-k] != m_pat[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model(input logic v, input logic d, input logic ld,
                         input logic [7:0] p, input logic [3:0] l,
                         input logic o, input logic r);
        exp_t e;
        if (r) begin
            m_pat = 8'h09; m_len = 4; m_ovl = 1'b0; m_err = 1'b0;
            bits_q.delete(); m_cnt = 0; m_dout = 1'b0;
        end else if (ld) begin
            m_pat = p; m_len = int'(l); m_ovl = o;
            m_err = (m_len == 0) || (m_len > 8);
            bits_q.delete(); m_cnt = 0; m_dout = 1'b0;
        end else if (v) begin
            bits_q.push_back(d);
            if (bits_q.size() > 8) void'(bits_q.pop_front());
            m_dout = !m_err && tail_matches();
            if (m_dout) begin
                m_cnt++;
                if (!m_ovl) bits_q.delete();
            end
        end else begin
            m_dout = 1'b0;
        end
        e.dout = m_dout;
        e.err  = m_err;
        e.c8   = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
        e.c2   = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic v, input logic d, input logic ld,
                        input logic [7:0] p, input logic [3:0] l,
                        input logic o, input logic r);
        @(negedge clk);
        reset = r; din = d; din_valid = v; cfg_load = ld;
        cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        model(v, d, ld, p, l, o, r);
    endtask

    task automatic bit_in(input logic d);  step(1'b1, d, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0); endtask
    task automatic idle();                 step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0); endtask
    task automatic do_reset();             step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1); endtask
    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        step(1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
    endtask

    // Sends bits[n-1:0], most significant (first) bit first
    task automatic send(input logic [15:0] bits, input int n);
        logic [15:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) bit_in(b[i]);
    endtask

    // Monitor: one expected entry per clock, compared away from the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (dout_a) pulses++;
                n_total++;
                if (dout_a === e.dout && err_a === e.err && cnt_a === e.c8 &&
                    dout_b === e.dout && err_b === e.err && cnt_b === e.c2)
                    n_pass++;
                else
                    $display("FAIL cycle@%0t: got dout=%b/%b err=%b/%b cnt=%0d/%0d expected dout=%b err=%b cnt=%0d/%0d",
                             $time, dout_a, dout_b, err_a, err_b, cnt_a, cnt_b,
                             e.dout, e.err, e.c8, e.c2);
            end
        end
    end

    // Stimulus: directed scenarios followed by random traffic
    initial begin
        int p0;
        int wait_cnt;
        do_reset();
        idle();
        check("reset_count", int'(cnt_a), 0);
        check("reset_err", int'(err_a), 0);
        check("reset_dout", int'(dout_a), 0);

        // 1: default "1001" non-overlap
        p0 = pulses;
        send(16'b1001001, 7); idle();
        check("t1_pulses", pulses - p0, 1);
        check("t1_count", int'(cnt_a), 1);

        // 2: overlap mode
        load(8'h09, 4'd4, 1'b1);
        p0 = pulses;
        send(16'b1001001, 7); idle();
        check("t2_pulses", pulses - p0, 2);
        check("t2_count", int'(cnt_a), 2);

        // 3: gaps do not break a partial match
        do_reset();
        p0 = pulses;
        bit_in(1'b1); bit_in(1'b0); idle(); idle(); idle(); bit_in(1'b0); bit_in(1'b1); idle();
        check("t3_pulses", pulses - p0, 1);
        check("t3_count", int'(cnt_a), 1);

        // 4: full-width pattern, then invalid length
        load(8'hA5, 4'd8, 1'b0);
        p0 = pulses;
        send(16'hA5A5, 16); idle();
        check("t4_pulses", pulses - p0, 2);
        check("t4_count", int'(cnt_a), 2);
        load(8'hA5, 4'd0, 1'b0); idle();
        check("t4_err", int'(err_a), 1);
        check("t4_clr", int'(cnt_a), 0);
        p0 = pulses;
        for (int i = 0; i < 20; i++) bit_in(1'($urandom_range(0, 1)));
        idle();
        check("t4_err_pulses", pulses - p0, 0);
        check("t4_err_count", int'(cnt_a), 0);
        load(8'hFF, 4'd9, 1'b1); idle();
        check("t4_err_len9", int'(err_a), 1);

        // 5: counter saturation (CNT_W=2 instance)
        load(8'h03, 4'd2, 1'b1);
        p0 = pulses;
        send(16'hFF, 8); idle();
        check("t5_pulses", pulses - p0, 7);
        check("t5_count8", int'(cnt_a), 7);
        check("t5_count2", int'(cnt_b), 3);

        // 6: reset mid-sequence, then reset together with cfg_load
        do_reset();
        p0 = pulses;
        send(16'b100, 3); do_reset(); bit_in(1'b1); idle();
        check("t6_pulses", pulses - p0, 0);
        step(1'b0, 1'b0, 1'b1, 8'h07, 4'd3, 1'b1, 1'b1);
        p0 = pulses;
        send(16'b1001, 4); idle();
        check("t6_default_pulses", pulses - p0, 1);

        // Random traffic with occasional reconfiguration and reset
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 2)
                load(8'($urandom), 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
            else if (sel < 3)
                do_reset();
            else if (sel < 75)
                bit_in(1'($urandom_range(0, 1)));
            else if (sel < 77)
                load(8'($urandom_range(0, 3)), 4'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
            else
                idle();
        end
        idle();

        // Bounded drain of the scoreboard
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
